// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: request/response bundle between the EX initiator and the
// RV32M multiply/divide unit.
interface md_issue_ctrl_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_busy;
  logic        md_valid;

  modport master (
    output md_start, md_op, md_a, md_b,
    input  md_result, md_busy, md_valid
  );

  modport slave (
    input  md_start, md_op, md_a, md_b,
    output md_result, md_busy, md_valid
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage issue, stall, hold and drain control for RV32M.
// Optional MD_RESULT_CACHE_EN keeps the last consumed DIV-class result.
module md_issue_ctrl #(
  parameter int WDOG_CYCLES = 64,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_md_en,
  input  logic [2:0]      ex_funct3,
  input  logic [31:0]     ex_rs1,
  input  logic [31:0]     ex_rs2,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_flush,
  input  logic            pipe_hold,
  output logic            md_stall,
  output logic            res_valid,
  output logic [31:0]     res_data,
  output logic [RD_W-1:0] res_rd,
  output logic            wdog_err,
  md_issue_ctrl_if.master md
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, DIV_WAIT, HOLD, DRAIN
  } state_e;

  state_e          state, nxt;
  logic [2:0]      op_q;
  logic [31:0]     a_q, b_q, res_q;
  logic [RD_W-1:0] rd_q;
  logic [CW-1:0]   wcnt;

  logic        req, is_div, hit, wdog_hit, cap;
  logic [31:0] cap_data, c_res;

  assign req      = ex_valid & ex_md_en & ~ex_flush;
  assign is_div   = ex_funct3[2];
  assign wdog_hit = (wcnt == CW'(WDOG_CYCLES)) & ~md.md_valid;

`ifdef MD_RESULT_CACHE_EN
  logic        c_vld, div_q, cwr;
  logic [2:0]  c_op;
  logic [31:0] c_a, c_b;

  assign hit = c_vld & (c_op == ex_funct3) &
               (c_a == ex_rs1) & (c_b == ex_rs2);
  // only results the pipeline actually took are worth remembering
  assign cwr = ~ex_flush & ~pipe_hold &
               (((state == DIV_WAIT) & md.md_valid) |
                ((state == HOLD) & div_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_op  <= '0;
      c_a   <= '0;
      c_b   <= '0;
      c_res <= '0;
      div_q <= 1'b0;
    end else begin
      if (cap) div_q <= (state == DIV_WAIT);
      if (wdog_err) begin
        c_vld <= 1'b0;
      end else if (cwr) begin
        c_vld <= 1'b1;
        c_op  <= op_q;
        c_a   <= a_q;
        c_b   <= b_q;
        c_res <= (state == HOLD) ? res_q : md.md_result;
      end
    end
  end
`else
  assign hit   = 1'b0;
  assign c_res = '0;
`endif

  always_comb begin
    nxt         = state;
    cap         = 1'b0;
    cap_data    = md.md_result;
    md.md_start = 1'b0;
    md.md_op    = '0;
    md.md_a     = '0;
    md.md_b     = '0;
    md_stall    = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_rd      = '0;
    wdog_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (is_div && hit) begin
            res_valid = 1'b1;
            res_data  = c_res;
            res_rd    = ex_rd;
            if (pipe_hold) begin
              nxt      = HOLD;
              cap      = 1'b1;
              cap_data = c_res;
            end
          end else if (md.md_busy) begin
            // unit still grinding after a timeout
            md_stall = 1'b1;
          end else begin
            md.md_start = 1'b1;
            md.md_op    = ex_funct3;
            md.md_a     = ex_rs1;
            md.md_b     = ex_rs2;
            if (is_div) begin
              md_stall = 1'b1;
              nxt      = DIV_WAIT;
            end else begin
              res_valid = 1'b1;
              res_data  = md.md_result;
              res_rd    = ex_rd;
              if (pipe_hold) begin
                nxt = HOLD;
                cap = 1'b1;
              end
            end
          end
        end
      end
      DIV_WAIT: begin
        md.md_op = op_q;
        md.md_a  = a_q;
        md.md_b  = b_q;
        if (md.md_valid) begin
          if (ex_flush) begin
            nxt = IDLE;
          end else begin
            res_valid = 1'b1;
            res_data  = md.md_result;
            res_rd    = rd_q;
            if (pipe_hold) begin
              nxt = HOLD;
              cap = 1'b1;
            end else begin
              nxt = IDLE;
            end
          end
        end else if (wdog_hit) begin
          wdog_err  = 1'b1;
          res_valid = ~ex_flush;
          res_rd    = ex_flush ? '0 : rd_q;
          nxt       = IDLE;
        end else begin
          md_stall = 1'b1;
          if (ex_flush) nxt = DRAIN;
        end
      end
      HOLD: begin
        res_valid = ~ex_flush;
        res_data  = ex_flush ? '0 : res_q;
        res_rd    = ex_flush ? '0 : rd_q;
        if (ex_flush || !pipe_hold) nxt = IDLE;
      end
      DRAIN: begin
        md.md_op = op_q;
        md.md_a  = a_q;
        md.md_b  = b_q;
        if (md.md_valid) begin
          md_stall = 1'b1;
          nxt      = IDLE;
        end else if (wdog_hit) begin
          wdog_err = 1'b1;
          nxt      = IDLE;
        end else begin
          md_stall = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      res_q <= '0;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == DIV_WAIT) begin
        op_q <= ex_funct3;
        a_q  <= ex_rs1;
        b_q  <= ex_rs2;
        rd_q <= ex_rd;
        wcnt <= CW'(1);
      end else if (state == DIV_WAIT || state == DRAIN) begin
        wcnt <= wcnt + CW'(1);
      end
      if (cap) begin
        res_q <= cap_data;
        if (state == IDLE) rd_q <= ex_rd;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized and directed checks of md_issue_ctrl against
// an arithmetic RV32M model and a cycle-count timing model.
module tb_md_issue_ctrl;

`ifdef MD_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_md_en, ex_flush, pipe_hold;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        md_stall, res_valid, wdog_err;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  int nvec = 0;
  int nerr = 0;

  bit          mute;
  bit          cv;
  logic [2:0]  cf;
  logic [31:0] ca, cb;

  md_issue_ctrl_if md();

  md_issue_ctrl #(.WDOG_CYCLES(64), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_md_en(ex_md_en),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_flush(ex_flush), .pipe_hold(pipe_hold),
    .md_stall(md_stall), .res_valid(res_valid),
    .res_data(res_data), .res_rd(res_rd),
    .wdog_err(wdog_err), .md(md)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] md_ref(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // unit model: MUL answers combinationally, DIV answers 34 cycles on
  logic        pend;
  int          dcnt;
  logic [31:0] dres;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      dcnt <= 0;
      dres <= '0;
    end else if (md.md_start && md.md_op[2]) begin
      pend <= 1'b1;
      dcnt <= 1;
      dres <= md_ref(md.md_op, md.md_a, md.md_b);
    end else if (pend) begin
      if (dcnt == 34 && !mute) pend <= 1'b0;
      else if (dcnt < 34) dcnt <= dcnt + 1;
    end
  end

  always_comb begin
    md.md_valid  = 1'b0;
    md.md_result = '0;
    md.md_busy   = pend && (dcnt < 34 || mute);
    if (pend && dcnt == 34 && !mute) begin
      md.md_valid  = 1'b1;
      md.md_result = dres;
    end else if (md.md_start && !md.md_op[2]) begin
      md.md_valid  = 1'b1;
      md.md_result = md_ref(md.md_op, md.md_a, md.md_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid  = 1'b0;
    ex_md_en  = 1'b0;
    ex_flush  = 1'b0;
    pipe_hold = 1'b0;
    ex_funct3 = '0;
    ex_rs1    = '0;
    ex_rs2    = '0;
    ex_rd     = '0;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input int hold, input logic [31:0] exp);
    bit hit;
    int lat;
    hit = CACHE_ON && f[2] && cv && cf == f && ca == a && cb == b;
    lat = (f[2] && !hit) ? 34 : 0;
    ex_valid  = 1'b1;
    ex_md_en  = 1'b1;
    ex_funct3 = f;
    ex_rs1    = a;
    ex_rs2    = b;
    ex_rd     = rd;
    for (int c = 0; c <= lat + hold; c++) begin
      pipe_hold = (c >= lat) && (c < lat + hold);
      @(negedge clk);
      nvec++;
      if (md_stall !== (c < lat)) begin
        nerr++;
        $display("FAIL stall op%0d c=%0d got %b want %b", f, c, md_stall, c < lat);
      end
      nvec++;
      if (res_valid !== (c >= lat)) begin
        nerr++;
        $display("FAIL res_valid op%0d c=%0d got %b", f, c, res_valid);
      end
      if (c >= lat) begin
        nvec++;
        if (res_data !== exp) begin
          nerr++;
          $display("FAIL res_data op%0d a=%h b=%h c=%0d got %h want %h",
                   f, a, b, c, res_data, exp);
        end
        nvec++;
        if (res_rd !== rd) begin
          nerr++;
          $display("FAIL res_rd c=%0d got %0d want %0d", c, res_rd, rd);
        end
      end
      nvec++;
      if (md.md_start !== (c == 0 && !hit)) begin
        nerr++;
        $display("FAIL md_start op%0d c=%0d got %b", f, c, md.md_start);
      end
      if (c == 0 && !hit) begin
        nvec++;
        if ({md.md_op, md.md_a, md.md_b} !== {f, a, b}) begin
          nerr++;
          $display("FAIL md_opnd got %0d %h %h want %0d %h %h",
                   md.md_op, md.md_a, md.md_b, f, a, b);
        end
      end
      nvec++;
      if ((md.md_start && md.md_busy) || wdog_err !== 1'b0) begin
        nerr++;
        $display("FAIL start_busy_wdog c=%0d got start=%b busy=%b wdog=%b want no overlap, no wdog",
                 c, md.md_start, md.md_busy, wdog_err);
      end
      step();
    end
    set_idle();
    if (f[2]) begin
      cv = 1'b1; cf = f; ca = a; cb = b;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({md_stall, res_valid, wdog_err, md.md_start} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_ctl got %b want 0000",
               {md_stall, res_valid, wdog_err, md.md_start});
    end
    nvec++;
    if ({res_data, res_rd, md.md_op, md.md_a, md.md_b} !== '0) begin
      nerr++;
      $display("FAIL reset_data got %h %h want 0", res_data, res_rd);
    end
    step();
    rst_n = 1'b1;
    cv = 1'b0;
    @(negedge clk);
    nvec++;
    if ({md_stall, res_valid, md.md_start} !== 3'b0) begin
      nerr++;
      $display("FAIL post_reset got %b want 000", {md_stall, res_valid, md.md_start});
    end
    step();
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'd6, 5'd1, 0, 32'd42);
  endtask

  task automatic test_div();
    do_op(3'd5, 32'd100, 32'd7, 5'd17, 0, 32'd14);
  endtask

  task automatic test_corners();
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd2, 0, 32'hFFFFFFFF);
    do_op(3'd5, 32'd5, 32'd0, 5'd3, 0, 32'hFFFFFFFF);
    do_op(3'd7, 32'd5, 32'd0, 5'd4, 0, 32'd5);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd5, 0, 32'h80000000);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0, 32'd0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd7, 0, 32'hFFFFFFFF);
  endtask

  task automatic test_hold();
    do_op(3'd3, 32'hFFFFFFFF, 32'd2, 5'd5, 3, 32'd1);
  endtask

  task automatic test_div_hold();
    do_op(3'd4, 32'hFFFFFF9C, 32'd7, 5'd8, 2, 32'hFFFFFFF2);
  endtask

  task automatic test_flush(input int fc);
    int mul_from;
    mul_from  = (fc == 34) ? 35 : fc + 2;
    ex_valid  = 1'b1;
    ex_md_en  = 1'b1;
    ex_funct3 = 3'd4;
    ex_rs1    = 32'd1000 + 32'(fc);
    ex_rs2    = 32'd7;
    ex_rd     = 5'd9;
    for (int c = 0; c <= 35; c++) begin
      ex_flush = (c == fc);
      if (c == fc + 1 && c < mul_from) ex_valid = 1'b0;
      if (c >= mul_from) begin
        ex_valid = 1'b1; ex_funct3 = 3'd0;
        ex_rs1 = 32'd9; ex_rs2 = 32'd5; ex_rd = 5'd3;
      end
      @(negedge clk);
      nvec++;
      if (res_valid !== (c == 35)) begin
        nerr++;
        $display("FAIL flush_res fc=%0d c=%0d got %b", fc, c, res_valid);
      end
      nvec++;
      if (md.md_start !== (c == 0 || c == 35)) begin
        nerr++;
        $display("FAIL flush_start fc=%0d c=%0d got %b", fc, c, md.md_start);
      end
      if (c < fc || (c >= mul_from && c < 35)) begin
        nvec++;
        if (md_stall !== 1'b1) begin
          nerr++;
          $display("FAIL flush_stall fc=%0d c=%0d got %b want 1", fc, c, md_stall);
        end
      end
      if (c == 35) begin
        nvec++;
        if ({md_stall, res_data, res_rd} !== {1'b0, 32'd45, 5'd3}) begin
          nerr++;
          $display("FAIL flush_mul got stall=%b %0d rd=%0d want 0 45 3",
                   md_stall, res_data, res_rd);
        end
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_flush_hold();
    ex_valid = 1'b1; ex_md_en = 1'b1; ex_funct3 = 3'd0;
    ex_rs1 = 32'd3; ex_rs2 = 32'd3; ex_rd = 5'd4;
    for (int c = 0; c <= 3; c++) begin
      pipe_hold = (c <= 2);
      ex_flush  = (c == 2);
      if (c == 3) ex_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if (res_valid !== (c < 2)) begin
        nerr++;
        $display("FAIL fh_valid c=%0d got %b", c, res_valid);
      end
      if (c < 2) begin
        nvec++;
        if (res_data !== 32'd9) begin
          nerr++;
          $display("FAIL fh_data c=%0d got %0d want 9", c, res_data);
        end
      end
      nvec++;
      if (md.md_start !== (c == 0)) begin
        nerr++;
        $display("FAIL fh_start c=%0d got %b", c, md.md_start);
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_cache();
    do_op(3'd5, 32'd200, 32'd9, 5'd11, 0, 32'd22);
    do_op(3'd5, 32'd200, 32'd9, 5'd12, 0, 32'd22);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    f = 0; a = 0; b = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || $urandom_range(3) != 0) begin
        f = 3'($urandom_range(7));
        a = $urandom;
        if ($urandom_range(3) == 0) b = 0;
        else if ($urandom_range(1) == 0) b = $urandom;
        else b = 32'($urandom_range(49));
      end
      do_op(f, a, b, 5'($urandom_range(31)), $urandom_range(2), md_ref(f, a, b));
    end
  endtask

  task automatic test_reset_midop();
    ex_valid = 1'b1; ex_md_en = 1'b1; ex_funct3 = 3'd5;
    ex_rs1 = 32'd9; ex_rs2 = 32'd3; ex_rd = 5'd1;
    repeat (5) step();
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    nvec++;
    if ({md_stall, res_valid, md.md_start, md.md_busy} !== 4'b0) begin
      nerr++;
      $display("FAIL midop_reset got %b want 0000",
               {md_stall, res_valid, md.md_start, md.md_busy});
    end
    step();
    rst_n = 1'b1;
    cv = 1'b0;
    do_op(3'd0, 32'd3, 32'd4, 5'd2, 0, 32'd12);
  endtask

  task automatic test_wdog();
    mute = 1'b1;
    ex_valid = 1'b1; ex_md_en = 1'b1; ex_funct3 = 3'd7;
    ex_rs1 = 32'd77; ex_rs2 = 32'd5; ex_rd = 5'd6;
    for (int c = 0; c <= 65; c++) begin
      if (c == 65) ex_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if (md_stall !== (c < 64)) begin
        nerr++;
        $display("FAIL wd_stall c=%0d got %b", c, md_stall);
      end
      nvec++;
      if ({wdog_err, res_valid} !== {2{c == 64}}) begin
        nerr++;
        $display("FAIL wd_pulse c=%0d got err=%b valid=%b", c, wdog_err, res_valid);
      end
      if (c == 64) begin
        nvec++;
        if ({res_data, res_rd} !== {32'd0, 5'd6}) begin
          nerr++;
          $display("FAIL wd_data got %h rd=%0d want 0 6", res_data, res_rd);
        end
      end
      nvec++;
      if (md.md_start !== (c == 0)) begin
        nerr++;
        $display("FAIL wd_start c=%0d got %b", c, md.md_start);
      end
      step();
    end
    set_idle();
    cv = 1'b0;
    mute = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    do_op(3'd5, 32'd81, 32'd9, 5'd7, 0, 32'd9);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    mute = 1'b0;
    cv = 1'b0; cf = '0; ca = '0; cb = '0;
    set_idle();
    rst_n = 1'b0;
    step();
    test_reset();
    test_mul();
    test_div();
    test_corners();
    test_hold();
    test_div_hold();
    test_flush(10);
    test_flush(34);
    test_flush_hold();
    test_cache();
    test_random();
    test_reset_midop();
    test_wdog();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- EX-stage initiator for the RV32M multiply/divide unit.
- Decodes M-extension requests from the pipeline and pulses the unit's start.
- Generates the EX stall while a divide is in flight, and buffers the result when the pipeline is held downstream.
- Drains an in-flight divide after a flush, because the unit has no kill input.

Parameters:
WDOG_CYCLES, 64, max cycles to wait for md_valid after a divide start before declaring a timeout error
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction
ex_md_en  in  1  EX instruction is RV32M
ex_funct3  in  3  M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
ex_rs1  in  32  operand a
ex_rs2  in  32  operand b
ex_rd  in  RD_W  destination register
ex_flush  in  1  kill the EX instruction this cycle
pipe_hold  in  1  downstream stall; EX cannot advance
md_stall  out  1  M result not yet available; EX must not advance
res_valid  out  1  result presented for the EX instruction
res_data  out  32  result value
res_rd  out  RD_W  result destination
wdog_err  out  1  one-cycle pulse on divide timeout
md_start  out  1  start pulse to the muldiv unit
md_op  out  3  md_op_e encoding, equal to funct3
md_a  out  32  operand a to the unit
md_b  out  32  operand b to the unit
md_result  in  32  unit result
md_busy  in  1  unit dividing
md_valid  in  1  unit result valid this cycle

Behaviour:
- Reset: all outputs 0; state IDLE; held registers 0.
- req = ex_valid & ex_md_en & !ex_flush. is_div = funct3[2]. EX advances when !md_stall & !pipe_hold.
- State IDLE:
  - If req, drive md_start=1 for exactly one cycle, with md_op/md_a/md_b taken from EX.
  - MUL class: md_valid returns in the same cycle. res_valid=1, res_data=md_result, md_stall=0. If pipe_hold, capture the result and go to HOLD.
  - DIV class: md_stall=1; go to DIV_WAIT.
- State DIV_WAIT:
  - md_start=0. md_op/md_a/md_b held at their issue values.
  - md_stall=1 until md_valid.
  - The unit asserts md_valid at T+34 (T = issue cycle). In that cycle: res_valid=1, md_stall=0.
  - If pipe_hold in that cycle, go to HOLD; otherwise go to IDLE.
  - ex_flush during DIV_WAIT: go to DRAIN; no res_valid is ever produced for the killed instruction.
- State HOLD:
  - Registered res_valid/res_data/res_rd held constant. md_stall=0. md_start is never reasserted for the same instruction.
  - Leave to IDLE on the first cycle with !pipe_hold (result consumed).
  - ex_flush: go to IDLE, result discarded.
- State DRAIN:
  - Wait for md_valid, discard it, go to IDLE the next cycle.
  - Any req arriving meanwhile sees md_stall=1 and is not issued until IDLE.
  - md_start must never pulse while md_busy=1.
- Watchdog:
  - Counter runs in DIV_WAIT and DRAIN.
  - If it reaches WDOG_CYCLES with no md_valid: pulse wdog_err, go to IDLE, drop md_stall. In DIV_WAIT also present res_valid with res_data=0.
- A flush and md_valid in the same cycle: the flush wins; the result is dropped.
- Reset asserted mid-operation returns the block to IDLE immediately. The unit is reset on the same rst_n.

Optional Feature:
MD_RESULT_CACHE_EN:
- Defined: keep one entry {op, a, b, result} for the last completed and consumed DIV-class result; drained results are not cached.
  - A DIV-class req that matches the entry exactly returns the cached result in the issue cycle, with md_start=0 and no stall.
  - The entry is invalidated on reset and on wdog_err.
- Undefined: every request issues to the unit.

Test Plan:
- MUL 7*6 with no hold -> md_start for 1 cycle, res_valid in the same cycle, res_data=42, md_stall never high.
- DIVU 100/7 issued at T -> md_start only at T, md_stall high T..T+33, res_valid at T+34 with res_data=14 and correct res_rd.
- REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV at T, flush at T+10, MUL requested from T+12 -> md_stall held, no res_valid for the DIV, MUL md_start at T+35, product returned that cycle.
- MULHU 0xFFFFFFFF*2 with pipe_hold high 3 cycles -> res_data=1 held stable 4 cycles, md_start count=1, IDLE after hold drops.
- Cache enabled: DIVU 100/7 twice back-to-back -> second returns 14 in its issue cycle with md_start=0. Cache disabled: second takes 35 cycles.
